// File: rtl/fir_pkg.sv
// Shared constants for the FIR output stage: accumulator and sample widths,
// the signed saturation window and the largest meaningful requant shift.
package fir_pkg;

  localparam int DIN_W     = 41;
  localparam int DOUT_W    = 16;
  localparam int SHIFT_W   = 6;

  // Beyond this shift the accumulator already fits the output sample.
  localparam int MAX_SHIFT = DIN_W - DOUT_W;

  localparam int SAT_MAX   = (1 << (DOUT_W - 1)) - 1;
  localparam int SAT_MIN   = -(1 << (DOUT_W - 1));

endpackage

// File: rtl/fir_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head entry is held in a
// register so it stays stable (and keeps the last popped value) when empty.
// A push into a full FIFO without a simultaneous pop is dropped and flagged.
module fir_sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             push_data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   fill_o,
  output logic                     drop_o
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   fill_q, fill_d;
  logic [W-1:0]  data_q, data_d;
  logic          valid_q;
  logic          full, pop, push_ok;

  // Next-state for pointers, occupancy and the registered head entry.
  always_comb begin
    full    = (fill_q == FULL_CNT);
    pop     = valid_q & pop_i;
    push_ok = push_i & (~full | pop);
    drop_o  = push_i & full & ~pop;
    rd_d    = pop     ? rd_q + AW'(1) : rd_q;
    wr_d    = push_ok ? wr_q + AW'(1) : wr_q;
    fill_d  = fill_q;
    if (push_ok && !pop)      fill_d = fill_q + (AW + 1)'(1);
    else if (pop && !push_ok) fill_d = fill_q - (AW + 1)'(1);
    // The new head is the incoming word when it lands exactly where the
    // read pointer ends up (FIFO empty apart from this push).
    data_d = data_q;
    if (fill_d != '0) data_d = (push_ok && wr_q == rd_d) ? push_data_i : mem_q[rd_d];
  end

  // Storage array write port.
  // NOTE: the storage array has no reset; occupancy and pointers alone decide
  // which entries are meaningful, and a reset on RAM-style arrays blocks
  // memory inference.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= push_data_i;
  end

  // Control state and the registered head/valid/fill outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed in always_comb.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      fill_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      valid_q <= (fill_d != '0);
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign fill_o  = fill_q;

endmodule

// File: rtl/fir_out_requant.sv
// FIR output requantiser: round, arithmetic-shift and saturate the 41-bit
// accumulator to a 16-bit sample, then buffer it in an FWFT FIFO with a
// valid/ready sink handshake and a sticky overflow flag.
// Optional build macro FIR_REQUANT_STATS_EN adds sat_cnt/drop_cnt counters.
module fir_out_requant #(
  parameter int DIN_W   = fir_pkg::DIN_W,
  parameter int DOUT_W  = fir_pkg::DOUT_W,
  parameter int SHIFT_W = fir_pkg::SHIFT_W,
  parameter int DEPTH   = 8
) (
  input  logic                    clk1,
  input  logic                    rst,
  input  logic [DIN_W-1:0]        din,
  input  logic                    valid_in,
  input  logic [SHIFT_W-1:0]      shift,
  output logic [DOUT_W-1:0]       dout,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  fill,
  output logic                    ovf,
  input  logic                    clr_ovf
`ifdef FIR_REQUANT_STATS_EN
  ,
  output logic [15:0]             sat_cnt,
  output logic [7:0]              drop_cnt
`endif
);

  import fir_pkg::*;

  localparam int                        EW     = DIN_W + 1;
  localparam logic [SHIFT_W-1:0]        MAX_SH = SHIFT_W'(MAX_SHIFT);
  localparam logic signed [EW-1:0]      HI     = EW'(SAT_MAX);
  localparam logic signed [EW-1:0]      LO     = EW'(SAT_MIN);
  localparam logic [DOUT_W-1:0]         HI_O   = DOUT_W'(SAT_MAX);
  localparam logic [DOUT_W-1:0]         LO_O   = DOUT_W'(SAT_MIN);

  logic [SHIFT_W-1:0]      shamt;
  logic signed [EW-1:0]    ext, rnd, s1_d, s1_q;
  logic                    s1_vld_q;
  logic [DOUT_W-1:0]       s2_d, s2_q;
  logic                    s2_vld_q;
  logic                    sat;
  logic                    drop;

  // Stage 1: clamp the shift, sign-extend, add the half-LSB and shift.
  // The extra bit keeps the rounding add from overflowing.
  always_comb begin
    shamt = (shift > MAX_SH) ? MAX_SH : shift;
    ext   = {din[DIN_W-1], din};
    rnd   = '0;
    if (shamt != '0) rnd[shamt - SHIFT_W'(1)] = 1'b1;
    s1_d  = (ext + rnd) >>> shamt;
  end

  // Stage 2: clip the shifted value into the signed output range.
  always_comb begin
    sat  = 1'b1;
    s2_d = s1_q[DOUT_W-1:0];
    if (s1_q > HI)      s2_d = HI_O;
    else if (s1_q < LO) s2_d = LO_O;
    else                sat  = 1'b0;
  end

  // Pipeline valid bits; cleared by reset so in-flight samples vanish.
  always_ff @(posedge clk1) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= valid_in;
      s2_vld_q <= s1_vld_q;
    end
  end

  // Pipeline data registers; qualified by the valid bits, so no reset.
  always_ff @(posedge clk1) begin
    s1_q <= s1_d;
    s2_q <= s2_d;
  end

  fir_sync_fifo #(
    .W     (DOUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk1),
    .rst         (rst),
    .push_i      (s2_vld_q),
    .push_data_i (s2_q),
    .pop_i       (out_ready),
    .data_o      (dout),
    .valid_o     (out_valid),
    .fill_o      (fill),
    .drop_o      (drop)
  );

  // Sticky overflow: a drop on the same edge as clr_ovf keeps it set.
  always_ff @(posedge clk1) begin
    if (rst)          ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (clr_ovf) ovf <= 1'b0;
  end

`ifdef FIR_REQUANT_STATS_EN
  // Saturating event counters for clipped and dropped samples.
  always_ff @(posedge clk1) begin
    if (rst || clr_ovf) begin
      sat_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (s1_vld_q && sat && sat_cnt != '1) sat_cnt  <= sat_cnt + 16'd1;
      if (drop && drop_cnt != '1)           drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fir_out_requant.sv
// Directed testbench for fir_out_requant: latency, rounding, saturation,
// overflow, full-FIFO streaming and mid-stream reset.
module tb_fir_out_requant;

  logic               clk1 = 1'b0;
  logic               rst;
  logic [40:0]        din;
  logic               valid_in;
  logic [5:0]         shift;
  logic signed [15:0] dout;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         fill;
  logic               ovf;
  logic               clr_ovf;
`ifdef FIR_REQUANT_STATS_EN
  logic [15:0]        sat_cnt;
  logic [7:0]         drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic signed [15:0] got[$];

  fir_out_requant dut (
    .clk1      (clk1),
    .rst       (rst),
    .din       (din),
    .valid_in  (valid_in),
    .shift     (shift),
    .dout      (dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fill      (fill),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf)
`ifdef FIR_REQUANT_STATS_EN
    ,
    .sat_cnt   (sat_cnt),
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk1 = ~clk1;

  // Record every sample the sink accepts (sampled mid-cycle, popped at next edge).
  always @(negedge clk1) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) got.push_back(dout);
  end

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send(input logic [40:0] d, input logic [5:0] sh);
    din      = d;
    shift    = sh;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    din = '0; shift = '0;
    idle(2);
    rst = 1'b0;
    checks++; if (dout !== 16'sd0) begin errors++; $display("FAIL reset_dout: got %0d expected 0", dout); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (fill !== 4'd0) begin errors++; $display("FAIL reset_fill: got %0d expected 0", fill); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`ifdef FIR_REQUANT_STATS_EN
    checks++; if (sat_cnt !== 16'd0) begin errors++; $display("FAIL reset_sat_cnt: got %0d expected 0", sat_cnt); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
`endif
  endtask

  task automatic test_latency();
    got.delete();
    out_ready = 1'b1;
    send(41'd100, 6'd0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_cycle1_valid: got %b expected 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_cycle2_valid: got %b expected 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_cycle3_valid: got %b expected 1", out_valid); end
    checks++; if (dout !== 16'sd100) begin errors++; $display("FAIL lat_dout: got %0d expected 100", dout); end
    checks++; if (fill !== 4'd1) begin errors++; $display("FAIL lat_fill: got %0d expected 1", fill); end
    step();
    checks++; if (fill !== 4'd0) begin errors++; $display("FAIL lat_fill_after_pop: got %0d expected 0", fill); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_valid_after_pop: got %b expected 0", out_valid); end
    checks++; if (dout !== 16'sd100) begin errors++; $display("FAIL lat_dout_hold: got %0d expected 100", dout); end
    checks++; if (got.size() != 1) begin errors++; $display("FAIL lat_accepted: got %0d samples expected 1", got.size()); end
  endtask

  task automatic test_rounding();
    int exp_v[3] = '{2, -1, 0};
    got.delete();
    out_ready = 1'b1;
    send(41'd24, 6'd4);
    send(-41'sd24, 6'd4);
    send(-41'sd8, 6'd4);
    idle(6);
    checks++; if (got.size() != 3) begin errors++; $display("FAIL round_count: got %0d expected 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== 16'(exp_v[i])) begin errors++; $display("FAIL round_value[%0d]: got %0d expected %0d", i, got[i], exp_v[i]); end
    end
  endtask

  task automatic test_saturation();
    int exp_v[3] = '{32767, -32768, 32767};
    pulse_clr();
    got.delete();
    out_ready = 1'b1;
    send(41'd40000, 6'd0);
    send(-41'sd40000, 6'd0);
    send(41'h0FFFFFFFFFF, 6'd40);
    idle(6);
    checks++; if (got.size() != 3) begin errors++; $display("FAIL sat_count: got %0d expected 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== 16'(exp_v[i])) begin errors++; $display("FAIL sat_value[%0d]: got %0d expected %0d", i, got[i], exp_v[i]); end
    end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sat_ovf: got %b expected 0", ovf); end
`ifdef FIR_REQUANT_STATS_EN
    checks++; if (sat_cnt !== 16'd3) begin errors++; $display("FAIL sat_cnt: got %0d expected 3", sat_cnt); end
`endif
  endtask

  task automatic test_overflow();
    got.delete();
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) send(41'(i), 6'd0);
    idle(4);
    checks++; if (fill !== 4'd8) begin errors++; $display("FAIL ovf_fill: got %0d expected 8", fill); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", ovf); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %b expected 1", out_valid); end
    checks++; if (dout !== 16'sd1) begin errors++; $display("FAIL ovf_head: got %0d expected 1", dout); end
`ifdef FIR_REQUANT_STATS_EN
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL ovf_drop_cnt: got %0d expected 1", drop_cnt); end
`endif
    out_ready = 1'b1;
    idle(10);
    checks++; if (got.size() != 8) begin errors++; $display("FAIL ovf_drain_count: got %0d expected 8", got.size()); end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== 16'(i + 1)) begin errors++; $display("FAIL ovf_drain[%0d]: got %0d expected %0d", i, got[i], i + 1); end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty_valid: got %b expected 0", out_valid); end
    checks++; if (fill !== 4'd0) begin errors++; $display("FAIL ovf_empty_fill: got %0d expected 0", fill); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", ovf); end
  endtask

  task automatic test_back_to_back();
    pulse_clr();
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL b2b_clr_ovf: got %b expected 0", ovf); end
`ifdef FIR_REQUANT_STATS_EN
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL b2b_clr_drop_cnt: got %0d expected 0", drop_cnt); end
`endif
    got.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(41'(10 + i), 6'd0);
    idle(4);
    checks++; if (fill !== 4'd8) begin errors++; $display("FAIL b2b_prefill: got %0d expected 8", fill); end
    // Stream 12 more; the sink wakes exactly when the first new sample arrives.
    shift = 6'd0;
    for (int i = 0; i < 12; i++) begin
      din      = 41'(100 + i);
      valid_in = 1'b1;
      if (i == 2) out_ready = 1'b1;
      step();
      if (i >= 2) begin
        checks++; if (fill !== 4'd8) begin errors++; $display("FAIL b2b_fill[%0d]: got %0d expected 8", i, fill); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf[%0d]: got %b expected 0", i, ovf); end
      end
    end
    valid_in = 1'b0;
    idle(15);
    checks++; if (got.size() != 20) begin errors++; $display("FAIL b2b_count: got %0d expected 20", got.size()); end
    for (int i = 0; i < 20 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== 16'((i < 8) ? 10 + i : 92 + i)) begin
        errors++; $display("FAIL b2b_order[%0d]: got %0d expected %0d", i, got[i], (i < 8) ? 10 + i : 92 + i);
      end
    end
    checks++; if (fill !== 4'd0) begin errors++; $display("FAIL b2b_final_fill: got %0d expected 0", fill); end
`ifdef FIR_REQUANT_STATS_EN
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL b2b_drop_cnt: got %0d expected 0", drop_cnt); end
`endif
  endtask

  task automatic test_reset_midstream();
    got.delete();
    out_ready = 1'b0;
    for (int i = 1; i <= 7; i++) send(41'(3 * i), 6'd0);
    checks++; if (fill !== 4'd5) begin errors++; $display("FAIL mid_prefill: got %0d expected 5", fill); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", out_valid); end
    checks++; if (fill !== 4'd0) begin errors++; $display("FAIL mid_fill: got %0d expected 0", fill); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL mid_ovf: got %b expected 0", ovf); end
    checks++; if (dout !== 16'sd0) begin errors++; $display("FAIL mid_dout: got %0d expected 0", dout); end
    out_ready = 1'b1;
    idle(6);
    checks++; if (got.size() != 0) begin errors++; $display("FAIL mid_ghost_samples: got %0d expected 0", got.size()); end
    checks++; if (fill !== 4'd0) begin errors++; $display("FAIL mid_fill_later: got %0d expected 0", fill); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_rounding();
    test_saturation();
    test_overflow();
    test_back_to_back();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
